// File: rtl/mult_pipe_sgn.sv
// Pipelined WIDTHA x WIDTHB multiplier with per-operand signedness and valid/ready flow control.
// Define MULT_ACC_EN to add the acc_clr input, ACC output and final-stage accumulator.
module mult_pipe_sgn #(
  parameter int unsigned WIDTHA = 16,
  parameter int unsigned WIDTHB = 24,
  parameter int unsigned STAGES = 4,
  parameter int unsigned ACCW   = WIDTHA + WIDTHB + 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTHA-1:0]        A,
  input  logic [WIDTHB-1:0]        B,
  input  logic                     a_signed,
  input  logic                     b_signed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTHA+WIDTHB-1:0] RES,
  output logic                     res_signed
`ifdef MULT_ACC_EN
  ,
  input  logic                     acc_clr,
  output logic [ACCW-1:0]          ACC
`endif
);

  localparam int unsigned PW = WIDTHA + WIDTHB;
  localparam int unsigned ND = STAGES - 1;

  if (WIDTHA < 2 || WIDTHB < 2 || STAGES < 2 || ACCW < WIDTHA + WIDTHB) begin : g_bad_param
    $error("mult_pipe_sgn: illegal parameter combination");
  end

  logic                   stall;
  logic                   adv;
  logic [WIDTHA:0]        ea_q, ea_d;
  logic [WIDTHB:0]        eb_q, eb_d;
  logic [STAGES-1:0]      vld_q, vld_d;
  logic [STAGES-1:0]      sgn_q, sgn_d;
  logic [ND-1:0][PW-1:0]  prod_q, prod_d;
  logic [PW-1:0]          prod;

  assign out_valid  = vld_q[STAGES-1];
  assign stall      = out_valid & ~out_ready;
  assign adv        = ~stall;
  assign in_ready   = adv;
  assign RES        = prod_q[ND-1];
  assign res_signed = sgn_q[STAGES-1];

  // Only the low PW bits of the product are kept, so PW-bit sign-extended operands suffice.
  assign prod = {{(WIDTHB-1){ea_q[WIDTHA]}}, ea_q} * {{(WIDTHA-1){eb_q[WIDTHB]}}, eb_q};

  always_comb begin
    ea_d   = ea_q;
    eb_d   = eb_q;
    vld_d  = vld_q;
    sgn_d  = sgn_q;
    prod_d = prod_q;
    if (adv) begin
      ea_d      = {a_signed & A[WIDTHA-1], A};
      eb_d      = {b_signed & B[WIDTHB-1], B};
      vld_d     = {vld_q[STAGES-2:0], in_valid};
      sgn_d     = {sgn_q[STAGES-2:0], a_signed | b_signed};
      prod_d[0] = prod;
      for (int unsigned k = 1; k < ND; k++) begin
        prod_d[k] = prod_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q   <= '0;
      eb_q   <= '0;
      vld_q  <= '0;
      sgn_q  <= '0;
      prod_q <= '0;
    end else begin
      ea_q   <= ea_d;
      eb_q   <= eb_d;
      vld_q  <= vld_d;
      sgn_q  <= sgn_d;
      prod_q <= prod_d;
    end
  end

`ifdef MULT_ACC_EN
  // clr only needs to reach the input of the final stage, where it is consumed.
  logic [STAGES-2:0] clr_q, clr_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [ACCW-1:0]   res_ext;

  assign ACC = acc_q;

  always_comb begin
    clr_d   = clr_q;
    acc_d   = acc_q;
    res_ext = sgn_d[STAGES-1] ? ACCW'($signed(prod_d[ND-1])) : ACCW'(prod_d[ND-1]);
    if (adv) begin
      clr_d[0] = acc_clr;
      for (int unsigned k = 1; k < STAGES - 1; k++) begin
        clr_d[k] = clr_q[k-1];
      end
      if (vld_d[STAGES-1]) begin
        acc_d = clr_q[STAGES-2] ? res_ext : acc_q + res_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_q <= '0;
      acc_q <= '0;
    end else begin
      clr_q <= clr_d;
      acc_q <= acc_d;
    end
  end
`endif

endmodule

// File: tb/tb_mult_pipe_sgn.sv
// Self-checking bench for mult_pipe_sgn: directed vectors, backpressure, bubbles, reset
// and randomized traffic against a queue-based arithmetic model.
module tb_mult_pipe_sgn;

  localparam int WA = 16;
  localparam int WB = 24;
  localparam int PW = WA + WB;
  localparam int AW = PW + 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] A;
  logic [WB-1:0] B;
  logic          a_signed;
  logic          b_signed;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] RES;
  logic          res_signed;
`ifdef MULT_ACC_EN
  logic [AW-1:0] ACC;
`endif

  always #5 clk = ~clk;

  mult_pipe_sgn dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .a_signed   (a_signed),
    .b_signed   (b_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .RES        (RES),
    .res_signed (res_signed)
`ifdef MULT_ACC_EN
    ,
    .acc_clr    (acc_clr),
    .ACC        (ACC)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [PW-1:0] res;
    logic          sgn;
    logic [AW-1:0] acc;
  } beat_t;

  beat_t         exp_q[$];
  int            n_out = 0;
  logic [AW-1:0] acc_m = '0;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_res = '0;

  // Product as plain integer arithmetic on the operands' numeric values.
  function automatic logic [PW-1:0] model_prod(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                               input logic as, input logic bs);
    longint av, bv, p;
    av = as ? longint'($signed(a)) : longint'(a);
    bv = bs ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    return p[PW-1:0];
  endfunction

  always @(negedge clk) begin
    beat_t         bt;
    logic [AW-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      acc_m      = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_res", RES, prev_res);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          bt = exp_q.pop_front();
          check_eq("sb_res", RES, bt.res);
          check_eq("sb_sgn", res_signed, bt.sgn);
`ifdef MULT_ACC_EN
          check_eq("sb_acc", ACC, bt.acc);
`endif
        end
      end
      if (in_valid && in_ready) begin
        bt.res = model_prod(A, B, a_signed, b_signed);
        bt.sgn = a_signed | b_signed;
        e      = bt.sgn ? {{(AW-PW){bt.res[PW-1]}}, bt.res} : {{(AW-PW){1'b0}}, bt.res};
        acc_m  = acc_clr ? e : acc_m + e;
        bt.acc = acc_m;
        exp_q.push_back(bt);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = RES;
    end
  end

  task automatic drain(input string tag);
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run_dir(input string tag, input logic [WA-1:0] a, input logic [WB-1:0] b,
                         input logic as, input logic bs, input logic clr,
                         input logic [PW-1:0] exp_res, input logic [AW-1:0] exp_acc);
    int lat = 0;
    @(posedge clk); #1;
    A = a; B = b; a_signed = as; b_signed = bs; acc_clr = clr;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_res"}, RES, exp_res);
    check_eq({tag, "_sgn"}, res_signed, as | bs);
`ifdef MULT_ACC_EN
    check_eq({tag, "_acc"}, ACC, exp_acc);
`else
    if (exp_acc != exp_acc) $display("unreachable");
`endif
  endtask

  initial begin
    int i;
    int guard;
    int n0;
    logic vin[20];
    logic vout[20];

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0;
    a_signed = 1'b0; b_signed = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_res", RES, 0);
    check_eq("rst_res_signed", res_signed, 0);
    rst_n = 1'b1;

    run_dir("u_10x5", 16'd10, 24'd5, 1'b0, 1'b0, 1'b1, 40'd50, 48'd50);
    run_dir("u_max", 16'hFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 40'hFFFEFF0001, 48'hFFFEFF0001);
    run_dir("s_m1x3", 16'hFFFF, 24'd3, 1'b1, 1'b1, 1'b1, 40'hFFFFFFFFFD, 48'hFFFFFFFFFFFD);
    run_dir("us_mix", 16'hFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 40'hFFFFFF0001, 48'hFFFFFFFF0001);
    run_dir("s_min", 16'h8000, 24'h800000, 1'b1, 1'b1, 1'b1, 40'h4000000000, 48'h4000000000);
`ifdef MULT_ACC_EN
    run_dir("acc0", 16'd2, 24'd3, 1'b0, 1'b0, 1'b1, 40'd6, 48'd6);
    run_dir("acc1", 16'd4, 24'd5, 1'b0, 1'b0, 1'b0, 40'd20, 48'd26);
    run_dir("acc2", 16'hFFFF, 24'd7, 1'b1, 1'b1, 1'b0, 40'hFFFFFFFFF9, 48'd19);
    run_dir("acc3", 16'd1, 24'd1, 1'b0, 1'b0, 1'b1, 40'd1, 48'd1);
`endif
    drain("dir");

    // Backpressure: fill with out_ready low, then release.
    n0 = n_out; i = 0;
    @(posedge clk); #1;
    out_ready = 1'b0; a_signed = 1'b0; b_signed = 1'b0; acc_clr = 1'b0;
    repeat (12) begin
      A = WA'(i); B = WB'(i + 1); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) i++;
      @(posedge clk); #1;
    end
    check_eq("bp_accepted", i, 4);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    out_ready = 1'b1; guard = 0;
    while (i < 8 && guard < 50) begin
      A = WA'(i); B = WB'(i + 1); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) i++;
      guard++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp_all_in", i, 8);
    drain("bp");
    check_eq("bp_out_count", n_out - n0, 8);

    // Bubbles: out_valid must replay the in_valid pattern four cycles later.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      in_valid = (k < 12) && (k % 2 == 0);
      A = WA'($urandom); B = WB'($urandom);
      @(negedge clk);
      vin[k]  = in_valid;
      vout[k] = out_valid;
    end
    for (int k = 4; k < 20; k++) check_eq("bubble_pattern", vout[k], vin[k-4]);
    drain("bub");

    // Randomized traffic with random backpressure.
    repeat (400) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = WA'($urandom);
      B         = WB'($urandom);
      a_signed  = 1'($urandom_range(0, 1));
      b_signed  = 1'($urandom_range(0, 1));
      acc_clr   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("rand");

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; A = WA'(k + 3); B = WB'(k + 11); a_signed = 1'b0; b_signed = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_res", RES, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = n_out;
    repeat (12) @(negedge clk);
    check_eq("rst_no_stale", n_out - n0, 0);
    run_dir("post_rst", 16'd7, 24'd9, 1'b0, 1'b0, 1'b1, 40'd63, 48'd63);
    drain("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
